// File: rtl/iter_alu.sv
// iter_alu: multi-cycle ALU with valid/ready handshake on both sides.
// Single-cycle logic/compare/shift ops, iterative shift-add MUL/MULHU and,
// when ITER_ALU_DIV_EN is defined, restoring DIVU/REMU. Without the macro
// ops 1110/1111 return 0 as single-cycle ops and no divider logic is built.
module iter_alu #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult
);
    localparam int SW = $clog2(DATA_WIDTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                     state, state_next;
    logic [CW-1:0]              cnt;
    logic [OPCODE_LENGTH-1:0]   op;
    logic [DATA_WIDTH-1:0]      opa;
    logic [2*DATA_WIDTH-1:0]    acc, acc_step;
    logic [DATA_WIDTH:0]        mul_sum;
    logic [SW-1:0]              shamt;
    logic [DATA_WIDTH-1:0]      quick_res, iter_res;
    logic                       accept, is_iter, last_step;
`ifdef ITER_ALU_DIV_EN
    logic [DATA_WIDTH-1:0]      opb, quo, quo_step;
    logic [DATA_WIDTH:0]        rem, rem_sh, rem_step;
    logic                       borrow;
`endif

    assign shamt     = SrcB[SW-1:0];
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == CW'(1));

    // Long ops: multiply always, divide only when the divider is built.
`ifdef ITER_ALU_DIV_EN
    assign is_iter = (Operation[3:2] == 2'b11);
`else
    assign is_iter = (Operation[3:1] == 3'b110);
`endif

    // Single-cycle result, computed straight from the accepted operands.
    always_comb begin
        quick_res = '0;
        case (Operation)
            4'b0000: quick_res = SrcA & SrcB;
            4'b0001: quick_res = SrcA | SrcB;
            4'b0010: quick_res = SrcA + SrcB;
            4'b0011: quick_res = SrcA ^ SrcB;
            4'b0100: quick_res = SrcA - SrcB;
            4'b0101: quick_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
            4'b0110: quick_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            4'b0111: quick_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) >= $signed(SrcB))};
            4'b1000: quick_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
            4'b1001: quick_res = SrcA << shamt;
            4'b1010: quick_res = SrcA >> shamt;
            4'b1011: quick_res = DATA_WIDTH'($signed(SrcA) >>> shamt);
            default: quick_res = '0;
        endcase
    end

    // One iteration step: shift-add on {hi,lo}, restore-subtract on {rem,quo}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
        acc_step = {mul_sum, acc[DATA_WIDTH-1:1]};
`ifdef ITER_ALU_DIV_EN
        rem_sh   = {rem[DATA_WIDTH-1:0], quo[DATA_WIDTH-1]};
        borrow   = rem_sh < {1'b0, opb};
        rem_step = borrow ? rem_sh : rem_sh - {1'b0, opb};
        quo_step = {quo[DATA_WIDTH-2:0], ~borrow};
`endif
        iter_res = '0;
        case (op)
            4'b1100: iter_res = acc_step[DATA_WIDTH-1:0];
            4'b1101: iter_res = acc_step[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef ITER_ALU_DIV_EN
            4'b1110: iter_res = quo_step;
            4'b1111: iter_res = rem_step[DATA_WIDTH-1:0];
`endif
            default: iter_res = '0;
        endcase
    end

    // Next state and handshake outputs; nothing is offered while in reset.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !reset;
                if (in_valid && !reset)
                    state_next = is_iter ? BUSY : DONE;
            end
            BUSY: if (last_step) state_next = DONE;
            DONE: begin
                out_valid = !reset;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, operand latches, iteration registers and the result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ALUResult <= '0;
            cnt       <= '0;
            op        <= '0;
            opa       <= '0;
            acc       <= '0;
`ifdef ITER_ALU_DIV_EN
            opb       <= '0;
            quo       <= '0;
            rem       <= '0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                op  <= Operation;
                opa <= SrcA;
                acc <= {{DATA_WIDTH{1'b0}}, SrcB};
                cnt <= is_iter ? CW'(DATA_WIDTH) : '0;
`ifdef ITER_ALU_DIV_EN
                opb <= SrcB;
                quo <= SrcA;
                rem <= '0;
`endif
                if (!is_iter) ALUResult <= quick_res;
            end else if (state == BUSY) begin
                acc <= acc_step;
                cnt <= cnt - CW'(1);
`ifdef ITER_ALU_DIV_EN
                quo <= quo_step;
                rem <= rem_step;
`endif
                if (last_step) ALUResult <= iter_res;
            end
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (DATA_WIDTH=32): directed cases plus
// randomized ops against a plain-arithmetic reference model.
module tb_iter_alu;
    logic        clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid;
    logic [31:0] SrcA = 0, SrcB = 0, ALUResult;
    logic [3:0]  Operation = 0;
    int          n_tests = 0, n_fail = 0;

    iter_alu #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (o)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return a - b;
            4'd5:  return {31'b0, a != b};
            4'd6:  return {31'b0, $signed(a) < $signed(b)};
            4'd7:  return {31'b0, $signed(a) >= $signed(b)};
            4'd8:  return {31'b0, a == b};
            4'd9:  return a << b[4:0];
            4'd10: return a >> b[4:0];
            4'd11: return $signed(a) >>> b[4:0];
            4'd12: return p[31:0];
            4'd13: return p[63:32];
`ifdef ITER_ALU_DIV_EN
            4'd14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd15: return (b == 0) ? a : a % b;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] o);
`ifdef ITER_ALU_DIV_EN
        return (o >= 4'd12) ? 33 : 1;
`else
        return (o == 4'd12 || o == 4'd13) ? 33 : 1;
`endif
    endfunction

    // Issue one op, measure latency, check result, stall a few cycles, then handshake.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        int          cyc;
        logic [31:0] exp;
        exp = model(o, a, b);
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, in_ready, 1);
        in_valid = 1; Operation = o; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        in_valid = 0; SrcA = $urandom; SrcB = $urandom; Operation = 4'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".lat"}, cyc, latency(o));
        chk({tag, ".res"}, ALUResult, exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_res"}, ALUResult, exp);
            chk({tag, ".hold_valid"}, out_valid, 1);
            chk({tag, ".hold_ready"}, in_ready, 0);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk({tag, ".drop_valid"}, out_valid, 0);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", in_ready, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.result", ALUResult, 0);
        @(negedge clk); reset = 0; #1;
        chk("post_rst.in_ready", in_ready, 1);

        run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'h1, 2);
        run_op("or", 4'd1, 32'h0000_F0F0, 32'h0000_0F0F, 0);
        run_op("lt", 4'd6, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("ge", 4'd7, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sra", 4'd11, 32'h8000_0000, 32'h21, 0);
        run_op("mul", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op("mulhu", 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("divu", 4'd14, 32'd100, 32'd7, 0);
        run_op("remu", 4'd15, 32'd100, 32'd7, 0);
        run_op("divu0", 4'd14, 32'h1234_5678, 32'd0, 0);
        run_op("remu0", 4'd15, 32'd5, 32'd0, 0);

        // Long stall with a competing request that must be ignored.
        @(negedge clk);
        in_valid = 1; Operation = 4'd2; SrcA = 32'd10; SrcB = 32'd20;
        @(posedge clk); #1;
        chk("hold.first_valid", out_valid, 1);
        chk("hold.first_res", ALUResult, 30);
        Operation = 4'd4; SrcA = 32'd1; SrcB = 32'd9;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold.res", ALUResult, 30);
            chk("hold.valid", out_valid, 1);
            chk("hold.in_ready", in_ready, 0);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("hold.drop_valid", out_valid, 0);
        chk("hold.in_ready_back", in_ready, 1);
        repeat (2) @(posedge clk); #1;
        chk("hold.no_ghost", out_valid, 0);

        // out_ready with nothing pending has no effect.
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("idle_ready.valid", out_valid, 0);
        chk("idle_ready.in_ready", in_ready, 1);

        // Reset during a MUL aborts it.
        @(negedge clk);
        in_valid = 1; Operation = 4'd12; SrcA = 32'd3; SrcB = 32'd4;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1; #1;
        chk("abort.in_ready_rst", in_ready, 0);
        @(negedge clk); reset = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort.no_output", seen, 0);
        chk("abort.result_cleared", ALUResult, 0);
        run_op("after_abort_add", 4'd2, 32'd2, 32'd3, 0);

        // Randomized ops.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            logic [3:0]  o;
            o = 4'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op("rand", o, a, b, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
